// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronises the serial line, samples mid-bit, and hands good bytes to an RX FIFO.
// Result pulses appear 3+HALF+9*CLKS_PER_BIT cycles after the start edge; a full FIFO drops the byte and pulses o_Overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_fifo_full,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_fifo_wr,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam logic [10:0] HALF = 11'((CLKS_PER_BIT - 1) / 2);
  localparam logic [10:0] LAST = 11'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  logic        rx_meta_q;
  logic        rx_q;
  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        wr_q, wr_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_q      <= rx_meta_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      wr_q    <= wr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    wr_d    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          // Line back high at mid-start means a glitch, not a frame.
          state_d = rx_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (rx_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
            if (!i_fifo_full) wr_d = 1'b1;
            else              ov_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      S_CLEANUP: begin
        cnt_d = '0;
        // Wait for an idle line so a break cannot start a new frame.
        if (rx_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign o_Rx_Byte   = byte_q;
  assign o_Rx_DV     = dv_q;
  assign o_fifo_wr   = wr_q;
  assign o_Frame_Err = fe_q;
  assign o_Overrun   = ov_q;
  assign o_Rx_Active = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule
